// File: rtl/rega_pkg.sv
// rtl/rega_pkg.sv - shared state, valve and error encodings for the irrigation sequencer
//
// Purpose: one place for the state numbering shown on the debug display, the
//          two-bit valve command consumed by the valve drivers, the error codes
//          and the "tank level sufficient" pattern.
// Ports:   none (package).
package rega_pkg;

   // Numbering is visible on the estado debug output, keep it stable.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ASP   = 3'd1,
      ST_GOT   = 3'd2,
      ST_LIMP  = 3'd3,
      ST_PAUSA = 3'd4,
      ST_ERRO  = 3'd5
   } estado_e;

   localparam logic [1:0] REGA_OFF = 2'b00;
   localparam logic [1:0] REGA_ASP = 2'b10;
   localparam logic [1:0] REGA_GOT = 2'b01;

   localparam logic [1:0] ERRO_NENHUM = 2'b00;
   localparam logic [1:0] ERRO_VE     = 2'b01;
   localparam logic [1:0] ERRO_NIVEL  = 2'b10;
   localparam logic [1:0] ERRO_AMBOS  = 2'b11;

   localparam logic [1:0] NIVEL_OK = 2'b11;

   function automatic logic [1:0] rega_decode(input estado_e st);
      case (st)
         ST_ASP:  return REGA_ASP;
         ST_GOT:  return REGA_GOT;
         default: return REGA_OFF;
      endcase
   endfunction

endpackage

// File: rtl/rega_timer.sv
// rtl/rega_timer.sv - loadable down-counter that times each irrigation phase
//
// Purpose: holds the remaining-cycle count of the active phase. A load
//          overrides the decrement; the count parks at zero.
// Ports:   clk, reset   - clock, asynchronous active-high reset
//          load         - load load_val on the next edge
//          load_val     - value to load (phase length minus one)
//          val          - current count
//          zero         - count is zero (last cycle of the phase)
module rega_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] val,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign val  = cnt_q;
   assign zero = (cnt_q == '0);

endmodule

// File: rtl/ctrl_rega.sv
// rtl/ctrl_rega.sv - irrigation sequencer: request latching, outlet arbitration, phase timing, abort
//
// Purpose: latches sprinkler / drip / cleaning requests, grants the shared
//          outlet to one at a time (cleaning > sprinkler > drip), times each
//          phase and aborts into a sticky error state on fill-valve or
//          tank-level conflicts.
// Option:  CTRL_REGA_PAUSA_EN - when defined, a rest phase of PAUSA_CICLOS
//          cycles follows every normal completion.
// Ports:   clk, reset         - clock, asynchronous active-high reset
//          req_asp/got/limpeza - requests (level or pulse)
//          ve                 - fill valve open
//          nivel              - tank level, 11 = sufficient
//          erro_ack           - leave the error state
//          rega               - valve command (10 sprinkler, 01 drip, 00 off)
//          limpando, ocupado  - cleaning active, not idle
//          fim                - one-cycle pulse after a normal completion
//          erro, erro_cod     - error state and cause (01 ve, 10 level, 11 both)
//          estado             - state register for debug/display
module ctrl_rega
   import rega_pkg::*;
#(
   parameter int ASP_CICLOS   = 8,
   parameter int GOT_CICLOS   = 16,
   parameter int LIMP_CICLOS  = 4,
   parameter int PAUSA_CICLOS = 3,
   parameter int CNT_W        = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_asp,
   input  logic       req_got,
   input  logic       req_limpeza,
   input  logic       ve,
   input  logic [1:0] nivel,
   input  logic       erro_ack,
   output logic [1:0] rega,
   output logic       limpando,
   output logic       ocupado,
   output logic       fim,
   output logic       erro,
   output logic [1:0] erro_cod,
   output logic [2:0] estado
);

   localparam logic [CNT_W-1:0] ASP_LOAD  = CNT_W'(ASP_CICLOS - 1);
   localparam logic [CNT_W-1:0] GOT_LOAD  = CNT_W'(GOT_CICLOS - 1);
   localparam logic [CNT_W-1:0] LIMP_LOAD = CNT_W'(LIMP_CICLOS - 1);
`ifdef CTRL_REGA_PAUSA_EN
   localparam logic [CNT_W-1:0] PAUSA_LOAD = CNT_W'(PAUSA_CICLOS - 1);
`else
   localparam int unused_pausa_ciclos = PAUSA_CICLOS;
`endif

   estado_e          state_q, state_d;
   logic             p_asp_q, p_asp_d;
   logic             p_got_q, p_got_d;
   logic             p_limp_q, p_limp_d;
   logic [1:0]       rega_q;
   logic             limpando_q, ocupado_q, erro_q;
   logic             fim_q, fim_d;
   logic [1:0]       erro_cod_q, erro_cod_d;

   logic             tmr_load;
   logic [CNT_W-1:0] tmr_load_val;
   logic [CNT_W-1:0] cnt_val_unused;
   logic             tmr_zero;

   logic             nivel_ok;
   logic             eff_asp, eff_got, eff_limp;
   logic             ent_asp, ent_got, ent_limp;
   logic             abort_ve, abort_niv;

   rega_timer #(
      .CNT_W(CNT_W)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .val      (cnt_val_unused),
      .zero     (tmr_zero)
   );

   assign nivel_ok = (nivel == NIVEL_OK);

   // The live input is OR'ed in so an IDLE request is served on this edge.
   assign eff_asp  = p_asp_q  | req_asp;
   assign eff_got  = p_got_q  | req_got;
   assign eff_limp = p_limp_q | req_limpeza;

   always_comb begin
      state_d      = state_q;
      tmr_load     = 1'b0;
      tmr_load_val = '0;
      fim_d        = 1'b0;
      erro_cod_d   = erro_cod_q;
      ent_asp      = 1'b0;
      ent_got      = 1'b0;
      ent_limp     = 1'b0;
      abort_ve     = 1'b0;
      abort_niv    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Blocked requests simply stay pending; no error is raised.
            if (eff_limp && !ve) begin
               state_d      = ST_LIMP;
               tmr_load     = 1'b1;
               tmr_load_val = LIMP_LOAD;
               ent_limp     = 1'b1;
            end else if (eff_asp && !ve && nivel_ok) begin
               state_d      = ST_ASP;
               tmr_load     = 1'b1;
               tmr_load_val = ASP_LOAD;
               ent_asp      = 1'b1;
            end else if (eff_got && !ve && nivel_ok) begin
               state_d      = ST_GOT;
               tmr_load     = 1'b1;
               tmr_load_val = GOT_LOAD;
               ent_got      = 1'b1;
            end
         end

         ST_ASP, ST_GOT, ST_LIMP: begin
            // Cleaning does not draw from the tank, so only ve aborts it.
            abort_ve  = ve;
            abort_niv = (state_q != ST_LIMP) && !nivel_ok;
            // Abort is checked first so it wins over a same-edge completion.
            if (abort_ve || abort_niv) begin
               state_d    = ST_ERRO;
               erro_cod_d = {abort_niv, abort_ve};
            end else if (tmr_zero) begin
               fim_d = 1'b1;
`ifdef CTRL_REGA_PAUSA_EN
               state_d      = ST_PAUSA;
               tmr_load     = 1'b1;
               tmr_load_val = PAUSA_LOAD;
`else
               state_d = ST_IDLE;
`endif
            end
         end

`ifdef CTRL_REGA_PAUSA_EN
         ST_PAUSA: begin
            if (tmr_zero) begin
               state_d = ST_IDLE;
            end
         end
`endif

         ST_ERRO: begin
            if (erro_ack) begin
               state_d    = ST_IDLE;
               erro_cod_d = ERRO_NENHUM;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Pending latches: dropped while in or entering ERRO (including the ack
   // edge), otherwise set by the request and cleared when that type starts.
   always_comb begin
      if ((state_q == ST_ERRO) || (state_d == ST_ERRO)) begin
         p_asp_d  = 1'b0;
         p_got_d  = 1'b0;
         p_limp_d = 1'b0;
      end else begin
         p_asp_d  = (p_asp_q  | req_asp)     & ~ent_asp;
         p_got_d  = (p_got_q  | req_got)     & ~ent_got;
         p_limp_d = (p_limp_q | req_limpeza) & ~ent_limp;
      end
   end

   // Outputs are decoded from the next state and registered, so they track
   // the state register cycle for cycle and cannot glitch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         p_asp_q    <= 1'b0;
         p_got_q    <= 1'b0;
         p_limp_q   <= 1'b0;
         rega_q     <= REGA_OFF;
         limpando_q <= 1'b0;
         ocupado_q  <= 1'b0;
         erro_q     <= 1'b0;
         fim_q      <= 1'b0;
         erro_cod_q <= ERRO_NENHUM;
      end else begin
         state_q    <= state_d;
         p_asp_q    <= p_asp_d;
         p_got_q    <= p_got_d;
         p_limp_q   <= p_limp_d;
         rega_q     <= rega_decode(state_d);
         limpando_q <= (state_d == ST_LIMP);
         ocupado_q  <= (state_d != ST_IDLE);
         erro_q     <= (state_d == ST_ERRO);
         fim_q      <= fim_d;
         erro_cod_q <= erro_cod_d;
      end
   end

   assign rega     = rega_q;
   assign limpando = limpando_q;
   assign ocupado  = ocupado_q;
   assign erro     = erro_q;
   assign fim      = fim_q;
   assign erro_cod = erro_cod_q;
   assign estado   = state_q;

endmodule

// File: tb/tb_ctrl_rega.sv
// tb/tb_ctrl_rega.sv - self-checking bench for the irrigation sequencer
module tb_ctrl_rega;

   localparam int ASP_N   = 8;
   localparam int GOT_N   = 16;
   localparam int LIMP_N  = 4;
   localparam int PAUSA_N = 3;
`ifdef CTRL_REGA_PAUSA_EN
   localparam int EXP_GAP   = PAUSA_N + 1;
   localparam int EXP_PAUSA = PAUSA_N;
`else
   localparam int EXP_GAP   = 1;
   localparam int EXP_PAUSA = 0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       req_asp, req_got, req_limpeza, ve, erro_ack;
   logic [1:0] nivel;
   logic [1:0] rega, erro_cod;
   logic       limpando, ocupado, fim, erro;
   logic [2:0] estado;
   logic [10:0] dut_v;

   int checks = 0;
   int errors = 0;

   // Reference model: phase number, cycles still to run, pending requests.
   int         m_ph;
   int         m_left;
   bit         m_pa, m_pg, m_pl;
   bit         m_fim;
   logic [1:0] m_cod;

   always #5 clk = ~clk;

   ctrl_rega dut (
      .clk        (clk),
      .reset      (reset),
      .req_asp    (req_asp),
      .req_got    (req_got),
      .req_limpeza(req_limpeza),
      .ve         (ve),
      .nivel      (nivel),
      .erro_ack   (erro_ack),
      .rega       (rega),
      .limpando   (limpando),
      .ocupado    (ocupado),
      .fim        (fim),
      .erro       (erro),
      .erro_cod   (erro_cod),
      .estado     (estado)
   );

   assign dut_v = {rega, limpando, ocupado, fim, erro, erro_cod, estado};

   function automatic logic [10:0] exp_v();
      logic [1:0] r;
      r = (m_ph == 1) ? 2'b10 : (m_ph == 2) ? 2'b01 : 2'b00;
      return {r, (m_ph == 3), (m_ph != 0), m_fim, (m_ph == 5), m_cod, 3'(m_ph)};
   endfunction

   task automatic model_clear();
      m_ph = 0; m_left = 0; m_pa = 0; m_pg = 0; m_pl = 0; m_fim = 0; m_cod = 2'b00;
   endtask

   // Advances the model by one clock using the inputs held across that edge.
   task automatic model_edge();
      int st;
      bit sa, sg, sl, ok, abv, abn;
      if (reset) begin
         model_clear();
         return;
      end
      st = m_ph; sa = 0; sg = 0; sl = 0; m_fim = 0;
      ok = (nivel == 2'b11);
      case (m_ph)
         0: begin
            if ((m_pl || req_limpeza) && !ve) begin m_ph = 3; m_left = LIMP_N; sl = 1; end
            else if ((m_pa || req_asp) && !ve && ok) begin m_ph = 1; m_left = ASP_N; sa = 1; end
            else if ((m_pg || req_got) && !ve && ok) begin m_ph = 2; m_left = GOT_N; sg = 1; end
         end
         1, 2, 3: begin
            abv = ve;
            abn = (m_ph != 3) && !ok;
            if (abv || abn) begin
               m_cod = {abn, abv};
               m_ph  = 5;
            end else begin
               m_left--;
               if (m_left == 0) begin
                  m_fim = 1;
`ifdef CTRL_REGA_PAUSA_EN
                  m_ph = 4; m_left = PAUSA_N;
`else
                  m_ph = 0;
`endif
               end
            end
         end
         4: begin
            m_left--;
            if (m_left == 0) m_ph = 0;
         end
         5: if (erro_ack) begin m_ph = 0; m_cod = 2'b00; end
         default: ;
      endcase
      if (st == 5 || m_ph == 5) begin
         m_pa = 0; m_pg = 0; m_pl = 0;
      end else begin
         m_pa = (m_pa || req_asp) && !sa;
         m_pg = (m_pg || req_got) && !sg;
         m_pl = (m_pl || req_limpeza) && !sl;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      req_asp = 0; req_got = 0; req_limpeza = 0; ve = 0; nivel = 2'b11; erro_ack = 0;
   endtask

   task automatic drain();
      idle_inputs();
      for (int i = 0; i < 60; i++) begin
         step();
         checks++;
         if (dut_v !== exp_v()) begin errors++; $display("FAIL drain_trace t=%0t dut=%b model=%b", $time, dut_v, exp_v()); end
      end
      checks++;
      if (estado !== 3'd0) begin errors++; $display("FAIL drain_idle estado=%0d expected 0", estado); end
   endtask

   task automatic test_reset();
      reset = 1;
      idle_inputs();
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (dut_v !== 11'd0) begin errors++; $display("FAIL reset_values dut=%b expected all zero", dut_v); end
      reset = 0;
      step();
      checks++;
      if (dut_v !== exp_v()) begin errors++; $display("FAIL reset_idle dut=%b model=%b", dut_v, exp_v()); end
   endtask

   task automatic test_asp_basic();
      int asp_cyc = 0, fims = 0;
      req_asp = 1;
      step();
      req_asp = 0;
      checks++;
      if (rega !== 2'b10) begin errors++; $display("FAIL asp_latency rega=%b expected 10", rega); end
      for (int i = 0; i < 12; i++) begin
         if (rega == 2'b10) asp_cyc++;
         if (fim) fims++;
         step();
         checks++;
         if (dut_v !== exp_v()) begin errors++; $display("FAIL asp_trace t=%0t dut=%b model=%b", $time, dut_v, exp_v()); end
      end
      checks++;
      if (asp_cyc != ASP_N) begin errors++; $display("FAIL asp_length got=%0d expected %0d", asp_cyc, ASP_N); end
      checks++;
      if (fims != 1) begin errors++; $display("FAIL asp_fim count=%0d expected 1", fims); end
      drain();
   endtask

   task automatic test_priority();
      int n_asp = 0, n_got = 0, n_limp = 0, fims = 0;
      int prev = 0;
      int order[$];
      for (int i = 0; i < 60; i++) begin
         req_asp = (i == 0); req_got = (i == 0); req_limpeza = (i == 1);
         step();
         checks++;
         if (dut_v !== exp_v()) begin errors++; $display("FAIL prio_trace t=%0t dut=%b model=%b", $time, dut_v, exp_v()); end
         if (int'(estado) != prev && estado inside {3'd1, 3'd2, 3'd3}) order.push_back(int'(estado));
         prev = int'(estado);
         if (rega == 2'b10) n_asp++;
         if (rega == 2'b01) n_got++;
         if (limpando) n_limp++;
         if (fim) fims++;
      end
      checks++;
      if (order.size() != 3 || order[0] != 1 || order[1] != 3 || order[2] != 2)
         begin errors++; $display("FAIL prio_order got=%p expected '{1,3,2}", order); end
      checks++;
      if (n_asp != ASP_N || n_limp != LIMP_N || n_got != GOT_N)
         begin errors++; $display("FAIL prio_lengths asp=%0d limp=%0d got=%0d expected 8 4 16", n_asp, n_limp, n_got); end
      checks++;
      if (fims != 3) begin errors++; $display("FAIL prio_fim count=%0d expected 3", fims); end
      drain();
   endtask

   task automatic test_abort();
      req_asp = 1;
      step();
      req_asp = 0;
      step();
      step();
      ve = 1;
      step();
      ve = 0;
      checks++;
      if (dut_v !== {2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 3'd5})
         begin errors++; $display("FAIL abort_ve dut=%b expected 00010101101", dut_v); end
      req_got = 1;
      step();
      checks++;
      if (dut_v !== exp_v()) begin errors++; $display("FAIL abort_sticky dut=%b model=%b", dut_v, exp_v()); end
      erro_ack = 1; req_asp = 1;
      step();
      erro_ack = 0; req_asp = 0; req_got = 0;
      checks++;
      if (estado !== 3'd0 || erro_cod !== 2'b00 || erro !== 1'b0)
         begin errors++; $display("FAIL abort_ack estado=%0d cod=%b erro=%b expected 0 00 0", estado, erro_cod, erro); end
      repeat (3) step();
      checks++;
      if (estado !== 3'd0 || ocupado !== 1'b0)
         begin errors++; $display("FAIL abort_no_pending estado=%0d ocupado=%b expected 0 0", estado, ocupado); end
      req_limpeza = 1;
      step();
      req_limpeza = 0;
      repeat (LIMP_N - 1) step();
      ve = 1;
      step();
      ve = 0;
      checks++;
      if (estado !== 3'd5 || fim !== 1'b0 || erro_cod !== 2'b01)
         begin errors++; $display("FAIL abort_wins_end estado=%0d fim=%b cod=%b expected 5 0 01", estado, fim, erro_cod); end
      erro_ack = 1;
      step();
      erro_ack = 0;
      drain();
   endtask

   task automatic test_blocked_level();
      int n_got = 0;
      nivel = 2'b01; req_got = 1;
      step();
      req_got = 0;
      repeat (4) step();
      checks++;
      if (estado !== 3'd0 || erro !== 1'b0)
         begin errors++; $display("FAIL blocked_idle estado=%0d erro=%b expected 0 0", estado, erro); end
      nivel = 2'b11;
      step();
      checks++;
      if (estado !== 3'd2) begin errors++; $display("FAIL blocked_start estado=%0d expected 2", estado); end
      for (int i = 0; i < 20; i++) begin
         if (rega == 2'b01) n_got++;
         step();
         checks++;
         if (dut_v !== exp_v()) begin errors++; $display("FAIL blocked_trace t=%0t dut=%b model=%b", $time, dut_v, exp_v()); end
      end
      checks++;
      if (n_got != GOT_N) begin errors++; $display("FAIL blocked_length got=%0d expected %0d", n_got, GOT_N); end
      drain();
   endtask

   task automatic test_back_to_back();
      int run1 = 0, gap = 0, pausa_seen = 0, phase = 0;
      req_got = 1;
      for (int i = 0; i < 50; i++) begin
         step();
         checks++;
         if (dut_v !== exp_v()) begin errors++; $display("FAIL b2b_trace t=%0t dut=%b model=%b", $time, dut_v, exp_v()); end
         case (phase)
            0: if (rega == 2'b01) begin phase = 1; run1 = 1; end
            1: if (rega == 2'b01) run1++;
               else begin phase = 2; gap = 1; if (estado == 3'd4 && ocupado) pausa_seen++; end
            2: if (rega == 2'b01) phase = 3;
               else begin gap++; if (estado == 3'd4 && ocupado) pausa_seen++; end
            default: ;
         endcase
      end
      req_got = 0;
      checks++;
      if (phase != 3 || run1 != GOT_N)
         begin errors++; $display("FAIL b2b_run phase=%0d run=%0d expected 3 %0d", phase, run1, GOT_N); end
      checks++;
      if (gap != EXP_GAP || pausa_seen != EXP_PAUSA)
         begin errors++; $display("FAIL b2b_gap gap=%0d pausa=%0d expected %0d %0d", gap, pausa_seen, EXP_GAP, EXP_PAUSA); end
      drain();
   endtask

   task automatic test_reset_mid();
      int fims = 0;
      req_got = 1;
      step();
      req_got = 0;
      repeat (4) step();
      reset = 1;
      #1;
      checks++;
      if (dut_v !== 11'd0) begin errors++; $display("FAIL reset_mid dut=%b expected all zero", dut_v); end
      model_clear();
      #2;
      reset = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (fim) fims++;
         checks++;
         if (dut_v !== exp_v()) begin errors++; $display("FAIL reset_mid_trace t=%0t dut=%b model=%b", $time, dut_v, exp_v()); end
      end
      checks++;
      if (fims != 0 || estado !== 3'd0)
         begin errors++; $display("FAIL reset_mid_resume fim=%0d estado=%0d expected 0 0", fims, estado); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         req_asp     = ($urandom_range(0, 7) == 0);
         req_got     = ($urandom_range(0, 7) == 0);
         req_limpeza = ($urandom_range(0, 11) == 0);
         ve          = ($urandom_range(0, 24) == 0);
         nivel       = ($urandom_range(0, 14) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
         erro_ack    = ($urandom_range(0, 5) == 0);
         reset       = ($urandom_range(0, 299) == 0);
         step();
         checks++;
         if (dut_v !== exp_v()) begin errors++; $display("FAIL random_trace t=%0t dut=%b model=%b", $time, dut_v, exp_v()); end
      end
      reset = 0;
      drain();
   endtask

   initial begin
      test_reset();
      test_asp_basic();
      test_priority();
      test_abort();
      test_blocked_level();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ctrl_rega.md
# ctrl_rega

Irrigation sequencer for the water-distribution datapath. Latches sprinkler (aspersão), drip (gotejamento) and cleaning requests, grants the shared outlet to one at a time, and times each cycle with a down-counter. Aborts into a sticky error state on fill-valve or tank-level conflicts. Sits between the user/keypad request logic and the valve drivers, producing the same `rega[1:0]` encoding the valve stage consumes: `10` = sprinkler, `01` = drip, `00` = off.

## Interface
- `ASP_CICLOS`, 8, sprinkler cycle length in clocks (≥1)
- `GOT_CICLOS`, 16, drip cycle length in clocks (≥1)
- `LIMP_CICLOS`, 4, cleaning cycle length in clocks (≥1)
- `PAUSA_CICLOS`, 3, rest interval after a completed cycle (used only with the macro; ≥1)
- `CNT_W`, 8, counter width; every *_CICLOS parameter must be ≤ 2^CNT_W
- `clk` in 1: clock, rising edge
- `reset` in 1: asynchronous, active-high; one clock, all state cleared
- `req_asp` in 1: sprinkler request; level or pulse, sampled every cycle
- `req_got` in 1: drip request
- `req_limpeza` in 1: cleaning request
- `ve` in 1: fill valve open (tank filling)
- `nivel` in 2: tank level state; `11` = level sufficient for irrigation
- `erro_ack` in 1: clears the error state
- `rega` out 2: valve command, `10` sprinkler, `01` drip, `00` off
- `limpando` out 1: cleaning active
- `ocupado` out 1: any state other than IDLE
- `fim` out 1: one-cycle pulse on normal cycle completion
- `erro` out 1: error state
- `erro_cod` out 2: `01` = ve conflict, `10` = level lost, `11` = both; `00` when no error
- `estado` out 3: state register, for debug/display

## Operation
- States: IDLE=0, ASP=1, GOT=2, LIMP=3, PAUSA=4, ERRO=5.
- Pending latches `p_asp`, `p_got`, `p_limp` are set by the matching request input when not in ERRO, and cleared on entry to the serving state.
- Effective request = latch OR input, so a request in IDLE is served with no extra cycle.
- IDLE arbitration uses fixed priority limpeza > asp > got:
  - LIMP starts when `ve`=0.
  - ASP/GOT start when `ve`=0 and `nivel`=11.
  - Blocked requests stay pending and raise no error.
- Counter loads `N-1` on entry and decrements each cycle. At 0 the block asserts `fim` and goes to PAUSA (macro on) or IDLE (macro off).
- Abort:
  - In ASP/GOT: `ve`=1 or `nivel`≠11 goes to ERRO.
  - In LIMP: `ve`=1 goes to ERRO.
  - `erro_cod` is latched on entry to ERRO. No `fim`.
- ERRO:
  - All outputs are off except `erro`/`erro_cod`/`ocupado`.
  - All pending latches are cleared, and requests are ignored.
  - `erro_ack` returns to IDLE and clears `erro_cod`.
- `rega`, `limpando`, `ocupado`, `erro` are decoded from the state register and are glitch-free by registering.
- A new request of a type already being served is latched and runs as a fresh cycle later.

## Timing
- Reset values: state IDLE, counter 0, latches 0, `rega`=00, `limpando`=0, `ocupado`=0, `fim`=0, `erro`=0, `erro_cod`=00, `estado`=0.
- Request high in IDLE before edge N: the state changes at edge N, and `rega` is active in the following cycle (latency 1).
- An active phase lasts exactly N cycles. `fim` is high in the first cycle after the phase.
- Abort condition high before edge M: ERRO from edge M. `rega`=00 in the following cycle.
- Simultaneous cycle end and abort condition on the same edge: abort wins (ERRO, no `fim`).
- `erro_ack` while not in ERRO: ignored. `erro_ack` together with new requests in ERRO: requests are dropped.
- Reset mid-cycle: immediate return to reset values; the cycle is not resumed.

## Configuration
- `CTRL_REGA_PAUSA_EN` defined: after every normal completion the block enters PAUSA for `PAUSA_CICLOS` cycles, with `rega`=00 and `ocupado`=1. Requests are latched during PAUSA. In PAUSA, `ve`/`nivel` do not cause errors. The block then returns to IDLE.
- Not defined: PAUSA state and its counter load are absent, and completion returns directly to IDLE.

## Structure
- Shared package `rega_pkg`: state enum, `rega` encodings (`REGA_OFF`/`REGA_ASP`/`REGA_GOT`), `erro_cod` constants, `NIVEL_OK`=2'b11.
- One sub-module, `rega_timer`: loadable down-counter with `load`, `val`, `zero` outputs. The FSM lives in `ctrl_rega`.

## Test plan
- Reset, then `req_asp` pulse with `nivel`=11, `ve`=0 → `rega`=10 for exactly 8 cycles, `fim` pulse, then back to IDLE.
- `req_asp` and `req_got` in the same cycle, plus `req_limpeza` one cycle later → sprinkler runs first (8 cycles), then cleaning (4), then drip (16); three `fim` pulses.
- ASP active, `ve` raised at cycle 3 → `rega`=00 next cycle, `erro`=1, `erro_cod`=01, no `fim`. `erro_ack` → IDLE with no pending requests.
- `req_got` with `nivel`=01 → stays IDLE, no error. Set `nivel`=11 → drip starts next cycle and runs 16 cycles.
- `CTRL_REGA_PAUSA_EN` on, `req_got` held high → GOT(16), PAUSA(3) with `rega`=00, GOT again.
- `reset` asserted mid-GOT → all outputs at reset values at once, no `fim`.
